// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Each pipeline stage resolves S = GROUP*GROUPS_PER_STAGE result bits with
// lookahead carries between GROUP-bit groups. The remaining operand bits and
// the finished lower result bits travel alongside, so every slice of one
// transaction leaves the last stage together. The handshake uses a single
// global stall: when the output is held, every stage holds.
module cla_pipe_adder #(
  parameter int WIDTH            = 32,
  parameter int GROUP            = 4,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int S      = GROUP * GROUPS_PER_STAGE;
  localparam int STAGES = WIDTH / S;

  if ((WIDTH % S) != 0 || STAGES < 1) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP*GROUPS_PER_STAGE");
  end

  // Operands still to be processed, partial result, and the carry into the
  // next unresolved slice (ovf is only meaningful in the last stage).
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
  } stage_t;

  typedef struct packed {
    logic [S-1:0] sum;
    logic         cout;
    logic         c_msb;   // carry into the top bit of the slice
  } slice_t;

  // One stage worth of CLA groups; the group carry-out is formed from the
  // group generate/propagate and feeds the next group's carry-in.
  function automatic slice_t slice_add(input logic [S-1:0] x,
                                       input logic [S-1:0] y,
                                       input logic         ci);
    slice_t           r;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic             gg;
    logic             pg;
    logic             c_grp;
    logic             c_bit;
    // NOTE: blocking assignments are correct here; this is pure combinational
    // evaluation where each line must see the value computed just above it.
    r     = '0;
    c_grp = ci;
    for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
      g     = x[j*GROUP +: GROUP] & y[j*GROUP +: GROUP];
      p     = x[j*GROUP +: GROUP] ^ y[j*GROUP +: GROUP];
      gg    = 1'b0;
      pg    = 1'b1;
      c_bit = c_grp;
      for (int i = 0; i < GROUP; i++) begin
        r.sum[j*GROUP+i] = p[i] ^ c_bit;
        if (j*GROUP + i == S-1) r.c_msb = c_bit;
        c_bit = g[i] | (p[i] & c_bit);
        gg    = g[i] | (p[i] & gg);
        pg    = pg & p[i];
      end
      c_grp = gg | (pg & c_grp);
    end
    r.cout = c_grp;
    return r;
  endfunction

  logic [STAGES-1:0] valid_q;
  stage_t            stage_q [STAGES];
  stage_t            stage_d [STAGES];
  stage_t            src     [STAGES];
  stage_t            in_stage;
  logic              advance;

  // Global stall: the pipe moves unless a finished result is being held.
  assign advance  = !valid_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + ~cin, so a borrow-in removes one more.
  always_comb begin
    in_stage       = '0;
    in_stage.a     = a;
    in_stage.b     = sub ? ~b : b;
    in_stage.carry = sub ? ~cin : cin;
  end

  assign src[0] = in_stage;
  for (genvar k = 1; k < STAGES; k++) begin : g_src
    assign src[k] = stage_q[k-1];
  end

  // Resolve slice k of whatever is entering stage k.
  always_comb begin
    slice_t sr;
    for (int k = 0; k < STAGES; k++) begin
      // NOTE: every element is fully assigned on every pass, so no latch is
      // inferred even though the loop body has no explicit else branches.
      sr                     = slice_add(src[k].a[k*S +: S], src[k].b[k*S +: S], src[k].carry);
      stage_d[k]             = src[k];
      stage_d[k].res[k*S +: S] = sr.sum;
      stage_d[k].carry       = sr.cout;
      stage_d[k].ovf         = sr.c_msb ^ sr.cout;
    end
  end

  // Shift valid bits every advance; load data only behind a valid bit so the
  // outputs hold the last real result while bubbles pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset along with the valid bits so that a
      // reset mid-transaction leaves result/cout/overflow at zero, not stale.
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignments let every stage read the old value of
      // its predecessor, which is what makes this a shift rather than a flush.
      valid_q[0] <= in_valid;
      if (in_valid) stage_q[0] <= stage_d[0];
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign result    = stage_q[STAGES-1].res;
  assign cout      = stage_q[STAGES-1].carry;
  assign overflow  = stage_q[STAGES-1].ovf;

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from GROUP-bit CLA slices.
- Successor to the fixed 32-bit ripple-of-CLA-groups array: width, group size and pipeline depth are configurable.
- Adds subtract mode, signed-overflow flag and a valid/ready handshake with backpressure.
- Sits on the multiplier's final-add path and serves as a general datapath adder.

Parameters:
- WIDTH, 32, operand/result width in bits.
- GROUP, 4, bits per CLA group; generate/propagate computed per group.
- GROUPS_PER_STAGE, 2, CLA groups resolved per pipeline stage. STAGES = WIDTH/(GROUP*GROUPS_PER_STAGE). WIDTH not divisible by GROUP*GROUPS_PER_STAGE is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  adder accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference.
- cout  out  1  carry-out. For sub: 1 = no borrow, 0 = borrow.
- overflow  out  1  two's-complement signed overflow.

Behaviour:
- Operand mapping: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. Arithmetic is {cout,result} = a + b_eff + c0, modulo 2^(WIDTH+1).
- overflow = carry into MSB XOR carry out of MSB.
- Pipeline structure:
  - Stage k (0..STAGES-1) resolves bit slice [k*S +: S], where S = GROUP*GROUPS_PER_STAGE.
  - Inside a stage, groups chain their carries: the group carry-out feeds the next group's carry-in.
  - The stage registers slice result, stage carry-out, and the still-unprocessed upper operand bits.
  - Already-computed lower result bits are delayed so all slices of one transaction emerge aligned.
- Latency: exactly STAGES cycles from the in_valid&&in_ready edge to out_valid, given no stall.
- Throughput: one transaction per cycle.
- Handshake:
  - advance = !out_valid || out_ready. in_ready = advance, combinational.
  - When advance=1, every stage shifts by one. An empty slot (valid bit 0) shifts as a bubble.
  - When advance=0, all stage registers hold and outputs stay stable.
  - Bubbles are not collapsed; the stall is global.
- Transfers:
  - Input transfer when in_valid && in_ready. If in_valid=0 while advancing, a bubble enters stage 0.
  - Output transfer when out_valid && out_ready.
  - A simultaneous input and output transfer in the same cycle is legal and keeps throughput at 1/cycle.
- Outputs are registered; out_valid is the valid bit of the last stage.
- While out_valid=0, the data outputs are don't-care but must be deterministic (held from the last load).
- Reset (asynchronous, any time, including mid-transaction):
  - All valid bits and all data/carry registers clear to 0.
  - out_valid=0, result=0, cout=0, overflow=0; in-flight transactions are discarded.
  - in_ready=1 during and after reset, since out_valid=0.
- The first accept may occur on the first rising edge after rst deasserts.

Test Plan:
- Default params, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 cycles: result=0x00000000, cout=1, overflow=0.
- a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, cout=0, overflow=1. Then a=0x80000000, b=1, sub=1 -> result=0x7FFFFFFF, cout=1, overflow=1.
- a=5, b=7, sub=1, cin=0 -> result=0xFFFFFFFE, cout=0 (borrow), overflow=0. Same operands with cin=1 -> result=0xFFFFFFFD.
- Back-to-back stream of 8 random ops with out_ready=1 -> one result per cycle in order, each matching the reference model, first result 4 cycles after first accept.
- Backpressure: hold out_ready=0 and feed continuously -> exactly 4 accepts, then in_ready=0. Outputs stay stable until out_ready=1, then the results drain in order with none lost or duplicated.
- Assert rst with 3 ops in flight -> out_valid=0 and result/cout/overflow=0 immediately, no stale result after release. Then re-run with WIDTH=16, GROUP=4, GROUPS_PER_STAGE=1 -> latency 4, 0xFFFF+0x0001 gives result 0x0000, cout=1.
